// File: rtl/mem_refill_ctrl.sv
// mem_refill_ctrl: memory-side refill engine for a cache line miss.
//
// This block takes a line-miss request and reads the whole line from memory.
// It starts with the missed (critical) word and wraps around the line.
// It returns each word to the cache controller as soon as the word arrives.
// When the last word is captured, it presents the assembled line with a
// one-cycle valid pulse.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst            synchronous reset, active low
//   req_cc2mem     level refill request, held by the controller until served
//   adr_cc2mem     miss address; word-in-line field selects the critical word
//   ack_mem2cc     one-cycle pulse per returned word (registered)
//   dat_mem2cc     returned word, valid with ack_mem2cc
//   word_mem2mshr  line word index of dat_mem2cc
//   line_mem2cc    assembled line, word i in slot i
//   line_vld       one-cycle pulse when all words of the line are captured
//   err_mem2cc     one-cycle pulse when a beat timed out and the burst aborted
//   mem_req        memory read request, high for the whole burst
//   mem_adr        memory word address {line base, word index, byte offset 0}
//   mem_ack        memory returns mem_dat this cycle
//   mem_dat        memory read data
module mem_refill_ctrl #(
  parameter int unsigned ADR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned WORD_OFFSET   = 2,
  // Must equal DATA_WIDTH * 2**WORD_OFFSET.
  parameter int unsigned DATAMEM_WIDTH = 128,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_cc2mem,
  input  logic [ADR_WIDTH-1:0]     adr_cc2mem,
  output logic                     ack_mem2cc,
  output logic [DATA_WIDTH-1:0]    dat_mem2cc,
  output logic [WORD_OFFSET-1:0]   word_mem2mshr,
  output logic [DATAMEM_WIDTH-1:0] line_mem2cc,
  output logic                     line_vld,
  output logic                     err_mem2cc,
  output logic                     mem_req,
  output logic [ADR_WIDTH-1:0]     mem_adr,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_dat
);

  localparam int unsigned Beats   = 2 ** WORD_OFFSET;
  localparam int unsigned ByteOff = $clog2(DATA_WIDTH / 8);
  localparam int unsigned BaseW   = ADR_WIDTH - WORD_OFFSET - ByteOff;
  // The timeout counter is 8 bits wide.
  // The abort happens on the TIMEOUT-th consecutive silent cycle.
  localparam logic [7:0]  TmoLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBurst, StDone, StHold} state_e;

  state_e                   state_q, state_d;
  logic [BaseW-1:0]         base_q, base_d;
  logic [WORD_OFFSET-1:0]   widx_q, widx_d;
  logic [WORD_OFFSET-1:0]   beat_q, beat_d;
  logic [7:0]               tmo_q, tmo_d;
  logic                     ack_q, ack_d;
  logic [DATA_WIDTH-1:0]    dat_q, dat_d;
  logic [WORD_OFFSET-1:0]   word_q, word_d;
  logic [DATAMEM_WIDTH-1:0] line_q, line_d;
  logic                     err_q, err_d;

  logic last_beat;
  logic timeout;
  logic unused_adr_bits;

  // mem_ack only counts while mem_req is high, which is exactly the BURST state.
  assign last_beat = (state_q == StBurst) && mem_ack && (beat_q == {WORD_OFFSET{1'b1}});
  assign timeout   = (state_q == StBurst) && !mem_ack && (tmo_q == TmoLast);

  // The byte offset within a word is irrelevant to a line refill.
  assign unused_adr_bits = ^adr_cc2mem[ByteOff-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_cc2mem) state_d = StBurst;
      StBurst: begin
        // A dropped request does not cut the burst short.
        // This keeps the line consistent.
        if (last_beat) begin
          state_d = StDone;
        end else if (timeout) begin
          state_d = StHold;
        end
      end
      StDone:  state_d = StHold;
      // A request that is still held must not start a second burst.
      StHold:  if (!req_cc2mem) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic decoded from state
  always_comb begin
    mem_req  = (state_q == StBurst);
    line_vld = (state_q == StDone);
  end

  // Datapath next-state
  always_comb begin
    base_d = base_q;
    widx_d = widx_q;
    beat_d = beat_q;
    tmo_d  = tmo_q;
    ack_d  = 1'b0;
    dat_d  = dat_q;
    word_d = word_q;
    line_d = line_q;
    err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_cc2mem) begin
          base_d = adr_cc2mem[ADR_WIDTH-1 -: BaseW];
          widx_d = adr_cc2mem[ByteOff +: WORD_OFFSET];
          beat_d = '0;
          tmo_d  = '0;
        end
      end
      StBurst: begin
        if (mem_ack) begin
          // Slots are overwritten one at a time.
          // The previous line stays visible until its slot is refilled.
          for (int unsigned i = 0; i < Beats; i++) begin
            if (widx_q == WORD_OFFSET'(i)) begin
              line_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_dat;
            end
          end
          ack_d  = 1'b1;
          dat_d  = mem_dat;
          word_d = widx_q;
          widx_d = widx_q + 1'b1;  // wraps within the line
          beat_d = beat_q + 1'b1;
          tmo_d  = '0;
        end else begin
          tmo_d = tmo_q + 8'd1;
          err_d = timeout;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q <= '0;
      widx_q <= '0;
      beat_q <= '0;
      tmo_q  <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      word_q <= '0;
      line_q <= '0;
      err_q  <= 1'b0;
    end else begin
      base_q <= base_d;
      widx_q <= widx_d;
      beat_q <= beat_d;
      tmo_q  <= tmo_d;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      word_q <= word_d;
      line_q <= line_d;
      err_q  <= err_d;
    end
  end

  assign ack_mem2cc    = ack_q;
  assign dat_mem2cc    = dat_q;
  assign word_mem2mshr = word_q;
  assign line_mem2cc   = line_q;
  assign err_mem2cc    = err_q;
  assign mem_adr       = {base_q, widx_q, {ByteOff{1'b0}}};

endmodule
